// File: rtl/y86_pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// y86_pipe_ctrl_pkg
// Shared definitions for the y86 pipeline control unit: instruction codes the
// controller decodes, the "no register" id, the condition-code reset value,
// the control FSM state encoding and the load-use hazard helper.
// No ports (package).
// ---------------------------------------------------------------------------
package y86_pipe_ctrl_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_MRMOVL = 4'h5;
  localparam logic [3:0] I_OPL    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPL   = 4'hB;

  localparam logic [3:0] R_NONE   = 4'hF;

  // {ZF, SF, OF} after reset: "result was zero"
  localparam logic [2:0] CC_RESET = 3'b100;

  typedef enum logic [1:0] {
    S_RUN       = 2'd0,
    S_RET_DRAIN = 2'd1,
    S_MEM_WAIT  = 2'd2,
    S_HALT      = 2'd3
  } ctrl_state_e;

  // A load in execute whose destination is read by the instruction in decode.
  // R_NONE never matches, so unused source fields cannot trigger a stall.
  function automatic logic load_use_hazard(input logic [3:0] e_icode,
                                           input logic [3:0] e_dst_m,
                                           input logic [3:0] src_a,
                                           input logic [3:0] src_b);
    return ((e_icode == I_MRMOVL) || (e_icode == I_POPL)) &&
           (e_dst_m != R_NONE) &&
           ((e_dst_m == src_a) || (e_dst_m == src_b));
  endfunction

endpackage

// File: rtl/y86_pipe_ctrl_if.sv
// ---------------------------------------------------------------------------
// y86_pipe_ctrl_if
// Bundle between the pipeline datapath and the pipeline control unit.
//   Pipeline -> control: D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
//                        alu_zf/sf/of, M_icode, mem_req, mem_ready, W_icode
//   Control -> pipeline: F/D/E/M/W_stall, D/E/M/W_bubble, cc_zf/sf/of, halted
// modport master : datapath side
// modport slave  : control unit side
// ---------------------------------------------------------------------------
interface y86_pipe_ctrl_if;

  logic [3:0] D_icode;
  logic [3:0] d_srcA;
  logic [3:0] d_srcB;
  logic [3:0] E_icode;
  logic [3:0] E_dstM;
  logic       e_Cnd;
  logic       alu_zf;
  logic       alu_sf;
  logic       alu_of;
  logic [3:0] M_icode;
  logic       mem_req;
  logic       mem_ready;
  logic [3:0] W_icode;

  logic       F_stall;
  logic       D_stall;
  logic       E_stall;
  logic       M_stall;
  logic       W_stall;
  logic       D_bubble;
  logic       E_bubble;
  logic       M_bubble;
  logic       W_bubble;
  logic       cc_zf;
  logic       cc_sf;
  logic       cc_of;
  logic       halted;

  modport master (
    output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
           alu_zf, alu_sf, alu_of, M_icode, mem_req, mem_ready, W_icode,
    input  F_stall, D_stall, E_stall, M_stall, W_stall,
           D_bubble, E_bubble, M_bubble, W_bubble,
           cc_zf, cc_sf, cc_of, halted
  );

  modport slave (
    input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
           alu_zf, alu_sf, alu_of, M_icode, mem_req, mem_ready, W_icode,
    output F_stall, D_stall, E_stall, M_stall, W_stall,
           D_bubble, E_bubble, M_bubble, W_bubble,
           cc_zf, cc_sf, cc_of, halted
  );

endinterface

// File: rtl/y86_pipe_ctrl_cc_reg.sv
// ---------------------------------------------------------------------------
// y86_pipe_ctrl_cc_reg
// Architectural condition-code register {ZF, SF, OF}.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, loads CC_RESET
//   en    : load d on the next rising edge
//   d     : new flags {zf, sf, of}
//   q     : current flags {zf, sf, of}
// ---------------------------------------------------------------------------
module y86_pipe_ctrl_cc_reg
  import y86_pipe_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] d,
  output logic [2:0] q
);

  // flag storage: load on enable, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= CC_RESET;
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/y86_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// y86_pipe_ctrl
// Stall/bubble generation for the five-stage y86 pipeline plus ownership of
// the condition-code register.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : y86_pipe_ctrl_if.slave (pipeline state in, stage controls and
//           condition codes out)
// Hazard priority, highest first: halt, memory wait, mispredicted jump,
// load-use, ret. Stage controls are combinational; state, the ret drain
// counter and the condition codes are registered.
// Parameter RET_BUBBLES : fetch-stall cycles per ret, detection cycle
//                         included (>= 1).
// Optional build macro Y86_PERF_CNT_EN adds parameter CNT_W and the wrapping
// counters cyc_cnt (non-halted cycles), stall_cnt (F_stall cycles) and
// bubble_cnt (E_bubble cycles).
// ---------------------------------------------------------------------------
module y86_pipe_ctrl
  import y86_pipe_ctrl_pkg::*;
#(
  parameter int RET_BUBBLES = 3
`ifdef Y86_PERF_CNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic           clk,
  input  logic           reset,
  y86_pipe_ctrl_if.slave bus
`ifdef Y86_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
`endif
);

  localparam int              RC_W     = (RET_BUBBLES > 1) ? $clog2(RET_BUBBLES) : 1;
  localparam logic [RC_W-1:0] RET_LOAD = RC_W'(RET_BUBBLES - 1);
  localparam logic [RC_W-1:0] RC_ONE   = RC_W'(1);

  ctrl_state_e     state_r, state_nxt_s;
  ctrl_state_e     saved_r, saved_nxt_s;
  ctrl_state_e     eff_state_s;
  logic [RC_W-1:0] ret_cnt_r, ret_cnt_nxt_s;

  logic mem_wait_s, mispredict_s, load_use_s, ret_start_s, drain_s, halt_s;
  logic cc_en_s;
  logic [2:0] cc_s;
  logic f_stall_s, d_stall_s, e_stall_s, m_stall_s, w_stall_s;
  logic d_bubble_s, e_bubble_s, m_bubble_s, w_bubble_s;

  // M_icode is carried on the bus for completeness; no hazard depends on it
  logic unused_m_icode_s;
  assign unused_m_icode_s = ^bus.M_icode;

  assign mem_wait_s   = bus.mem_req & ~bus.mem_ready;
  assign mispredict_s = (bus.E_icode == I_JXX) & ~bus.e_Cnd;
  assign load_use_s   = load_use_hazard(bus.E_icode, bus.E_dstM, bus.d_srcA, bus.d_srcB);
  assign halt_s       = (state_r == S_HALT);

  // Once the wait clears, MEM_WAIT behaves as the state it interrupted in the
  // same cycle, so a paused drain resumes without an extra idle cycle.
  assign eff_state_s  = (state_r == S_MEM_WAIT) ? saved_r : state_r;
  assign drain_s      = (eff_state_s == S_RET_DRAIN);
  // A ret behind a mispredicted jump is wrong-path; behind a load-use it is
  // re-evaluated once the stall has resolved.
  assign ret_start_s  = (eff_state_s == S_RUN) & (bus.D_icode == I_RET) &
                        ~load_use_s & ~mispredict_s;

  // stage controls from state and current hazards
  always_comb begin
    f_stall_s  = 1'b0;
    d_stall_s  = 1'b0;
    e_stall_s  = 1'b0;
    m_stall_s  = 1'b0;
    w_stall_s  = 1'b0;
    d_bubble_s = 1'b0;
    e_bubble_s = 1'b0;
    m_bubble_s = 1'b0;
    w_bubble_s = 1'b0;
    if (!reset) begin
      f_stall_s = 1'b0;
    end else if (halt_s) begin
      f_stall_s = 1'b1;
      d_stall_s = 1'b1;
      e_stall_s = 1'b1;
      m_stall_s = 1'b1;
      w_stall_s = 1'b1;
    end else if (mem_wait_s) begin
      f_stall_s  = 1'b1;
      d_stall_s  = 1'b1;
      e_stall_s  = 1'b1;
      m_stall_s  = 1'b1;
      w_bubble_s = 1'b1;
    end else begin
      f_stall_s  = load_use_s | ret_start_s | drain_s;
      d_stall_s  = load_use_s;
      // a held D register must not also be bubbled
      d_bubble_s = (mispredict_s | ret_start_s | drain_s) & ~load_use_s;
      e_bubble_s = mispredict_s | load_use_s;
    end
  end

  // next state, saved state and ret drain counter
  always_comb begin
    state_nxt_s   = state_r;
    saved_nxt_s   = saved_r;
    ret_cnt_nxt_s = ret_cnt_r;
    if (halt_s || (bus.W_icode == I_HALT)) begin
      state_nxt_s = S_HALT;
    end else if (mem_wait_s) begin
      state_nxt_s = S_MEM_WAIT;
      saved_nxt_s = eff_state_s;
    end else if (ret_start_s) begin
      ret_cnt_nxt_s = RET_LOAD;
      state_nxt_s   = (RET_BUBBLES > 1) ? S_RET_DRAIN : S_RUN;
    end else if (drain_s) begin
      ret_cnt_nxt_s = ret_cnt_r - RC_ONE;
      state_nxt_s   = (ret_cnt_r == RC_ONE) ? S_RUN : S_RET_DRAIN;
    end else begin
      state_nxt_s = S_RUN;
    end
  end

  // control state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= S_RUN;
      saved_r   <= S_RUN;
      ret_cnt_r <= {RC_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      saved_r   <= saved_nxt_s;
      ret_cnt_r <= ret_cnt_nxt_s;
    end
  end

  // Flags only come from an OPL that really retires its execute result.
  assign cc_en_s = (bus.E_icode == I_OPL) & ~mem_wait_s & ~halt_s & ~mispredict_s;

  y86_pipe_ctrl_cc_reg u_cc_reg (
    .clk   (clk),
    .rst_n (reset),
    .en    (cc_en_s),
    .d     ({bus.alu_zf, bus.alu_sf, bus.alu_of}),
    .q     (cc_s)
  );

  assign bus.F_stall  = f_stall_s;
  assign bus.D_stall  = d_stall_s;
  assign bus.E_stall  = e_stall_s;
  assign bus.M_stall  = m_stall_s;
  assign bus.W_stall  = w_stall_s;
  assign bus.D_bubble = d_bubble_s;
  assign bus.E_bubble = e_bubble_s;
  assign bus.M_bubble = m_bubble_s;
  assign bus.W_bubble = w_bubble_s;
  assign bus.cc_zf    = cc_s[2];
  assign bus.cc_sf    = cc_s[1];
  assign bus.cc_of    = cc_s[0];
  assign bus.halted   = halt_s;

`ifdef Y86_PERF_CNT_EN
  // performance counters, free-running with natural wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_cnt    <= {CNT_W{1'b0}};
      stall_cnt  <= {CNT_W{1'b0}};
      bubble_cnt <= {CNT_W{1'b0}};
    end else begin
      cyc_cnt    <= halt_s     ? cyc_cnt : (cyc_cnt + CNT_W'(1));
      stall_cnt  <= f_stall_s  ? (stall_cnt + CNT_W'(1)) : stall_cnt;
      bubble_cnt <= e_bubble_s ? (bubble_cnt + CNT_W'(1)) : bubble_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_y86_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_y86_pipe_ctrl
// Directed stimulus for y86_pipe_ctrl. A behavioural model (remaining ret
// stall cycles, halted flag, condition codes) predicts every output; a
// compare process checks the DUT against it on each falling edge, and
// literal expectations at key points pin the model itself.
// ---------------------------------------------------------------------------
module tb_y86_pipe_ctrl;
  import y86_pipe_ctrl_pkg::*;

  localparam int         RB  = 3;
  localparam logic [3:0] NOP = 4'h1;

  // control vector: {F,D,E,M,W stall, D,E,M,W bubble}
  localparam logic [8:0] C_NONE = 9'b00000_0000;
  localparam logic [8:0] C_LU   = 9'b11000_0100;
  localparam logic [8:0] C_RET  = 9'b10000_1000;
  localparam logic [8:0] C_MP   = 9'b00000_1100;
  localparam logic [8:0] C_WAIT = 9'b11110_0001;
  localparam logic [8:0] C_HALT = 9'b11111_0000;
  localparam logic [8:0] C_FST  = 9'b10000_0000;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  y86_pipe_ctrl_if bus ();

`ifdef Y86_PERF_CNT_EN
  logic [31:0] cyc_cnt, stall_cnt, bubble_cnt;
`endif

  y86_pipe_ctrl #(.RET_BUBBLES(RB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef Y86_PERF_CNT_EN
    ,
    .cyc_cnt    (cyc_cnt),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic       m_halted;
  int         m_left;   // fetch-stall cycles still owed to a ret
  logic [2:0] m_cc;

  function automatic logic m_wait();
    return bus.mem_req && !bus.mem_ready;
  endfunction

  function automatic logic m_mp();
    return (bus.E_icode == I_JXX) && !bus.e_Cnd;
  endfunction

  function automatic logic m_lu();
    logic is_load;
    is_load = (bus.E_icode == I_MRMOVL) || (bus.E_icode == I_POPL);
    if (!is_load || bus.E_dstM == R_NONE) return 1'b0;
    return (bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB);
  endfunction

  function automatic logic [12:0] model_expect();
    logic [8:0] c;
    logic lu, mp, go, drn;
    c   = C_NONE;
    lu  = m_lu();
    mp  = m_mp();
    go  = (m_left == 0) && (bus.D_icode == I_RET) && !lu && !mp;
    drn = (m_left > 0) || go;
    if (!reset) c = C_NONE;
    else if (m_halted) c = C_HALT;
    else if (m_wait()) c = C_WAIT;
    else begin
      if (lu) c = c | C_LU;
      if (mp) c = c | C_MP;
      if (drn) c = c | (lu ? C_FST : C_RET);
    end
    return {c, m_cc, m_halted};
  endfunction

  // model state advance on each edge
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_halted <= 1'b0;
      m_left   <= 0;
      m_cc     <= 3'b100;
    end else begin
      if (!m_halted && !m_wait()) begin
        if (m_left > 0) m_left <= m_left - 1;
        else if (bus.D_icode == I_RET && !m_lu() && !m_mp()) m_left <= RB - 1;
        if (bus.E_icode == I_OPL && !m_mp()) m_cc <= {bus.alu_zf, bus.alu_sf, bus.alu_of};
      end
      if (bus.W_icode == I_HALT) m_halted <= 1'b1;
    end
  end

  function automatic logic [12:0] obs();
    return {bus.F_stall, bus.D_stall, bus.E_stall, bus.M_stall, bus.W_stall,
            bus.D_bubble, bus.E_bubble, bus.M_bubble, bus.W_bubble,
            bus.cc_zf, bus.cc_sf, bus.cc_of, bus.halted};
  endfunction

  task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t: got ctl=%b cc=%b halted=%b, want ctl=%b cc=%b halted=%b",
               name, $time, got[12:4], got[3:1], got[0], exp[12:4], exp[3:1], exp[0]);
    end
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) check("cycle", obs(), model_expect());

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [8:0] ctl, input logic [2:0] cc, input logic h);
    #1;
    check(name, obs(), {ctl, cc, h});
  endtask

  task automatic idle();
    bus.D_icode   = NOP;
    bus.d_srcA    = R_NONE;
    bus.d_srcB    = R_NONE;
    bus.E_icode   = NOP;
    bus.E_dstM    = R_NONE;
    bus.e_Cnd     = 1'b1;
    bus.alu_zf    = 1'b0;
    bus.alu_sf    = 1'b0;
    bus.alu_of    = 1'b0;
    bus.M_icode   = NOP;
    bus.mem_req   = 1'b0;
    bus.mem_ready = 1'b1;
    bus.W_icode   = NOP;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #2 reset = 1'b0;

    // reset: controls forced low even with a load-use pattern present
    tick();
    bus.E_icode = I_MRMOVL; bus.E_dstM = 4'd3; bus.d_srcA = 4'd3;
    chk("rst_ctl", C_NONE, 3'b100, 1'b0);
    tick(); idle();
    chk("rst_idle", C_NONE, 3'b100, 1'b0);
    reset = 1'b1;
    tick();

    // OPL loads flags {0,1,0}
    bus.E_icode = I_OPL; bus.alu_sf = 1'b1;
    chk("opl_pre", C_NONE, 3'b100, 1'b0);
    tick(); idle();
    chk("opl_post", C_NONE, 3'b010, 1'b0);

    // load-use on srcA, guarded R_NONE case, POPL on srcB
    bus.E_icode = I_MRMOVL; bus.E_dstM = 4'd3; bus.d_srcA = 4'd3;
    chk("lu_srca", C_LU, 3'b010, 1'b0);
    tick(); idle();
    chk("lu_clear", C_NONE, 3'b010, 1'b0);
    bus.E_icode = I_MRMOVL; bus.E_dstM = R_NONE;
    chk("lu_rnone", C_NONE, 3'b010, 1'b0);
    tick(); idle();
    bus.E_icode = I_POPL; bus.E_dstM = 4'd4; bus.d_srcB = 4'd4;
    chk("lu_popl", C_LU, 3'b010, 1'b0);
    tick(); idle();

    // ret: exactly RB fetch-stall cycles
    bus.D_icode = I_RET;
    chk("ret_0", C_RET, 3'b010, 1'b0);
    tick(); idle();
    for (int i = 1; i < RB; i++) begin
      chk("ret_n", C_RET, 3'b010, 1'b0);
      tick();
    end
    chk("ret_end", C_NONE, 3'b010, 1'b0);

    // mispredict squashes a wrong-path ret
    bus.E_icode = I_JXX; bus.e_Cnd = 1'b0; bus.D_icode = I_RET;
    chk("mp_ret", C_MP, 3'b010, 1'b0);
    tick(); idle();
    chk("mp_nodrain", C_NONE, 3'b010, 1'b0);
    tick();

    // load-use beats ret; ret restarts the next cycle
    bus.D_icode = I_RET; bus.E_icode = I_MRMOVL; bus.E_dstM = 4'd3; bus.d_srcA = 4'd3;
    chk("lu_ret", C_LU, 3'b010, 1'b0);
    tick(); idle(); bus.D_icode = I_RET;
    chk("ret_retry", C_RET, 3'b010, 1'b0);
    tick(); idle();
    chk("retry_1", C_RET, 3'b010, 1'b0);
    tick();
    chk("retry_2", C_RET, 3'b010, 1'b0);
    tick();
    chk("retry_end", C_NONE, 3'b010, 1'b0);

    // memory wait in the middle of a drain, flags frozen
    bus.D_icode = I_RET;
    chk("w_ret0", C_RET, 3'b010, 1'b0);
    tick(); idle();
    bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    bus.E_icode = I_OPL; bus.alu_zf = 1'b1; bus.alu_sf = 1'b1; bus.alu_of = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("w_hold", C_WAIT, 3'b010, 1'b0);
      tick();
    end
    idle();
    chk("w_res1", C_RET, 3'b010, 1'b0);
    tick();
    chk("w_res2", C_RET, 3'b010, 1'b0);
    tick();
    chk("w_done", C_NONE, 3'b010, 1'b0);
    bus.mem_req = 1'b1; bus.mem_ready = 1'b1;
    chk("mem_rdy", C_NONE, 3'b010, 1'b0);
    tick(); idle();

    // halt, sticky against later activity, cleared only by async reset
    bus.W_icode = I_HALT;
    chk("halt_pre", C_NONE, 3'b010, 1'b0);
    tick(); idle();
    chk("halt_on", C_HALT, 3'b010, 1'b1);
    bus.E_icode = I_OPL; bus.alu_of = 1'b1; bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    tick();
    chk("halt_hold", C_HALT, 3'b010, 1'b1);
    reset = 1'b0;
    chk("halt_rst", C_NONE, 3'b100, 1'b0);
    tick(); idle();
    reset = 1'b1;
    tick();
    chk("post_rst", C_NONE, 3'b100, 1'b0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/y86_pipe_ctrl.md
Name: y86_pipe_ctrl

Overview:
Pipeline control unit for the five-stage y86 pipeline (F/D/E/M/W).
- Generates per-stage stall/bubble controls for load-use hazards, mispredicted jumps, ret drains, memory wait-states and halt.
- Owns the architectural condition-code register (ZF/SF/OF), loaded from ALU flags. The execute stage reads these flags to evaluate jXX/cmovXX conditions.
- Sits beside the pipeline registers; all of them take its stall/bubble outputs.

Parameters:
- RET_BUBBLES, 3: number of fetch-stall cycles inserted per ret, including the detection cycle (min 1).
- CNT_W, 32: width of the performance counters (only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- D_icode  input  4  icode in decode
- d_srcA  input  4  decode source register A (R_NONE if unused)
- d_srcB  input  4  decode source register B
- E_icode  input  4  icode in execute
- E_dstM  input  4  memory-destination register in execute
- e_Cnd  input  1  condition result from execute
- alu_zf, alu_sf, alu_of  input  1 each  flags from the ALU in the current cycle
- M_icode  input  4  icode in memory stage
- mem_req  input  1  memory stage has an access outstanding
- mem_ready  input  1  data memory completes the access this cycle
- W_icode  input  4  icode in writeback
- F_stall, D_stall, E_stall, M_stall, W_stall  output  1 each  hold the stage register
- D_bubble, E_bubble, M_bubble, W_bubble  output  1 each  load a nop into the stage register
- cc_zf, cc_sf, cc_of  output  1 each  condition-code register
- halted  output  1  pipeline stopped on halt

Behaviour:
- Reset (async, reset==0):
  - State goes to RUN and the ret counter goes to 0.
  - CC is set to ZF=1, SF=0, OF=0 and halted=0.
  - All stall/bubble outputs are 0 while in reset.
- FSM states: RUN, RET_DRAIN, MEM_WAIT, HALT. Stall/bubble outputs are combinational from state and inputs. State, counter and CC are registered.
- mem_wait = mem_req & ~mem_ready.
- Priority, highest first: halt, mem_wait, mispredict, load-use, ret.
- HALT:
  - Entered on the clock edge where W_icode==I_HALT, from any state.
  - In HALT, all five stalls are 1, all bubbles are 0 and halted=1.
  - HALT is left only by reset.
- mem_wait (any state except HALT):
  - F/D/E/M stall = 1, W_bubble = 1, all other outputs 0.
  - The current state is saved. MEM_WAIT returns to the saved state on the first cycle with mem_wait==0.
  - The ret counter and CC are frozen.
- Mispredict: E_icode==I_JXX & ~e_Cnd (predict-taken scheme). Asserts D_bubble=1 and E_bubble=1.
  - A ret in D on that cycle is wrong-path: no drain starts.
  - An active RET_DRAIN is not affected.
- Load-use: E_icode in {I_MRMOVL, I_POPL} & E_dstM!=R_NONE & (E_dstM==d_srcA | E_dstM==d_srcB). Asserts F_stall=1, D_stall=1, E_bubble=1.
- Ret start: in RUN, D_icode==I_RET with no load-use and no mispredict.
  - Asserts F_stall=1 and D_bubble=1.
  - Counter loads RET_BUBBLES-1. The next state is RET_DRAIN if RET_BUBBLES>1, otherwise RUN.
  - If load-use coincides, load-use wins and the ret is re-evaluated next cycle.
- RET_DRAIN:
  - Asserts F_stall=1 and D_bubble=1.
  - Counter decrements each non-wait cycle. At 1 it returns to RUN.
- CC update:
  - On a clock edge with E_icode==I_OPL, not mem_wait, not halted and not E being squashed by mispredict: cc <= {alu_zf, alu_sf, alu_of}.
  - Otherwise CC holds.
- Outputs for a non-RUN state and a coincident hazard are the OR of both requirements; stall and bubble are never both 1 for the same stage.

Optional Feature:
Y86_PERF_CNT_EN:
- Defined: adds output ports cyc_cnt, stall_cnt, bubble_cnt, each CNT_W wide, all reset to 0.
  - cyc_cnt increments every cycle that is not HALT.
  - stall_cnt increments on cycles with F_stall=1.
  - bubble_cnt increments on cycles with E_bubble=1.
  - All three wrap at 2^CNT_W.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared y86_define.v holds the icode constants (I_HALT, I_JXX, I_RET, I_OPL, I_MRMOVL, I_POPL), R_NONE, and the new FSM state encodings (S_RUN, S_RET_DRAIN, S_MEM_WAIT, S_HALT).
- One natural sub-module: y86_cc_reg, the 3-bit condition-code register with its enable and reset value.

Test Plan:
- Reset then OPL with alu flags {0,1,0} -> next cycle cc={0,1,0}; before it, cc={1,0,0}, all controls 0.
- E_icode=MRMOVL, E_dstM=3, d_srcA=3 -> F_stall=D_stall=E_bubble=1 for one cycle; with E_dstM=R_NONE -> no stall.
- D_icode=RET, RET_BUBBLES=3 -> F_stall=D_bubble=1 for exactly 3 cycles, then all 0.
- E_icode=JXX, e_Cnd=0, D_icode=RET same cycle -> D_bubble=E_bubble=1, F_stall=0, no drain follows.
- mem_req=1, mem_ready=0 for 4 cycles during RET_DRAIN (count=2) -> F/D/E/M stall plus W_bubble for 4 cycles; the drain then resumes with 2 cycles left and CC is unchanged.
- W_icode=HALT -> halted=1 and all stalls 1 from the next edge; reset=0 mid-halt -> halted=0 immediately (async).
